mux2x1_sel_arbiter: RTL and testbench
=====================================

Name: mux2x1_sel_arbiter

Overview:
Registered select controller that sits directly upstream of the 2:1 mux and drives its `select` input.
- Arbitrates between two requesting sources, in1 and in2, in round-robin order.
- Each grant is held for a bounded dwell time.
- Also emits a registered copy of the granted data, so downstream logic sees the mux result with a valid qualifier.

Parameters:
WIDTH, 1, data width of in1, in2 and out.
DWELL, 4, maximum cycles per grant tenure; legal range 1..255; counter width is $clog2(DWELL+1), minimum 1.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
req1  input  1  source 1 requests the mux.
req2  input  1  source 2 requests the mux.
in1  input  WIDTH  source 1 data.
in2  input  WIDTH  source 2 data.
select  output  1  registered mux select: 0 = in1, 1 = in2.
grant1  output  1  registered; source 1 currently owns the mux.
grant2  output  1  registered; source 2 currently owns the mux.
out  output  WIDTH  registered mux result.
valid  output  1  out holds data captured during a grant.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, select=0, grant1=0, grant2=0, out=0, valid=0, count=0.
  - last_served=in2, so the first tie goes to in1.
- States: IDLE, GRANT1, GRANT2. All outputs are registered; no combinational path from inputs to outputs.
- IDLE:
  - req1 & ~req2 -> GRANT1.
  - ~req1 & req2 -> GRANT2.
  - req1 & req2 -> grant the source that is not last_served.
  - Neither request -> stay in IDLE.
- Latency: a request sampled at edge N produces grant, select, out and valid updated together at edge N (visible in cycle N+1).
- Entry to GRANTx:
  - count <= DWELL-1.
  - select <= x-1.
  - grantx <= 1, the other grant <= 0.
  - last_served <= x.
- In GRANTx, at every edge:
  - out <= inx, valid <= 1.
  - count decrements while nonzero.
- Tenure ends at the edge where count==0 or reqx==0. Next state:
  - Other source requesting -> other GRANT, direct handoff with no idle cycle; select flips on that edge.
  - Else reqx still high -> same GRANT, re-armed with count <= DWELL-1.
  - Else -> IDLE.
- Capture rule: at an edge where reqx is sampled low, out is not updated with inx.
- Entering IDLE: grant1=grant2=0, valid=0. out and select hold their last values.
- DWELL=1: a grant lasts one cycle; with both requesting, select toggles every cycle.
- Maximum tenure is DWELL cycles; neither source can hold the mux longer while the other requests.
- Reset asserted mid-grant: all outputs return immediately to reset values. After release, arbitration restarts with the in1 tie preference.
- Request changes inside a tenure do not preempt; only the end-of-tenure decision samples them.

Optional Feature:
- Macro: MUX_SEL_PRIORITY_EN.
- When defined:
  - Fixed priority replaces round-robin: in1 always wins ties at IDLE and at every end-of-tenure decision.
  - last_served is not implemented.
  - in2 is granted only when req1 is low at a decision point.
- When undefined: round-robin as described above.

Test Plan:
1. Reset values: assert rst=1 asynchronously mid-cycle -> immediately select=0, grant1=grant2=0, out=0, valid=0. Release rst with no requests -> outputs unchanged for 5 cycles.
2. Single request: DWELL=4, req1=1 held, in1=1, req2=0 -> grant1=1, select=0 and valid=1 one edge later. out=1 every cycle. Re-arm every 4 cycles with no gap.
3. Tie and alternation: DWELL=4, req1=req2=1 from reset, in1=0, in2=1:
   - grant1 for 4 cycles, then grant2 for 4 cycles, repeating.
   - select pattern 0000 1111 0000; out follows 0/1 with one-cycle register delay.
4. Early release: req2 alone granted, then req2 drops on cycle 2 of the tenure -> next edge IDLE, valid=0, grant2=0, select stays 1, out holds the last in2 value.
5. Reset mid-grant: during GRANT2 with count=2, pulse rst -> outputs return to reset values immediately. With both requesting after release, in1 is granted first.
6. MUX_SEL_PRIORITY_EN defined, DWELL=2, req1=req2=1 continuously -> grant1 held indefinitely, select=0 forever. Dropping req1 -> grant2 at the next decision edge.

Source files
------------

// File: rtl/mux2x1_sel_arbiter.sv
// mux2x1_sel_arbiter
//   Registered select controller for a 2:1 mux. Two sources (in1, in2)
//   are arbitrated round-robin. Each grant tenure lasts at most DWELL
//   cycles. A registered copy of the granted data is also produced.
//
//   Optional feature macro: MUX_SEL_PRIORITY_EN
//     When defined, in1 wins every tie (fixed priority) and no
//     last-served history is kept.
//
// Parameters
//   WIDTH  data width of in1, in2 and out
//   DWELL  maximum cycles per grant tenure (1..255)
//
// Ports
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   req1    source 1 request
//   req2    source 2 request
//   in1     source 1 data
//   in2     source 2 data
//   select  registered mux select (0 = in1, 1 = in2)
//   grant1  registered, source 1 owns the mux
//   grant2  registered, source 2 owns the mux
//   out     registered mux result
//   valid   out holds data captured during a grant
module mux2x1_sel_arbiter #(
  parameter int WIDTH = 1,
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req1,
  input  logic             req2,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             select,
  output logic             grant1,
  output logic             grant2,
  output logic [WIDTH-1:0] out,
  output logic             valid
);

  localparam int             CW     = (DWELL < 2) ? 1 : $clog2(DWELL + 1);
  localparam logic [CW-1:0]  RELOAD = CW'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, GRANT1, GRANT2} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count;
  logic          arm;       // next edge starts a fresh tenure
  logic          tie_to2;   // winner of a simultaneous request at IDLE

`ifdef MUX_SEL_PRIORITY_EN
  assign tie_to2 = 1'b0;
`else
  // 1 when source 2 was the most recently granted source
  logic last_served2;
  assign tie_to2 = ~last_served2;
`endif

  // Next state. Requests are only examined at IDLE and at the
  // end of a tenure; changes mid-tenure never preempt.
  always_comb begin
    state_nxt = state;
    arm       = 1'b0;
    case (state)
      IDLE: begin
        if (req1 && req2) state_nxt = tie_to2 ? GRANT2 : GRANT1;
        else if (req1)    state_nxt = GRANT1;
        else if (req2)    state_nxt = GRANT2;
        arm = (state_nxt != IDLE);
      end
      GRANT1: begin
        if (count == '0 || !req1) begin
`ifdef MUX_SEL_PRIORITY_EN
          if (req1)      state_nxt = GRANT1;
          else if (req2) state_nxt = GRANT2;
          else           state_nxt = IDLE;
`else
          if (req2)      state_nxt = GRANT2;
          else if (req1) state_nxt = GRANT1;
          else           state_nxt = IDLE;
`endif
          arm = (state_nxt != IDLE);
        end
      end
      GRANT2: begin
        // Source 1 takes over first under both policies.
        if (count == '0 || !req2) begin
          if (req1)      state_nxt = GRANT1;
          else if (req2) state_nxt = GRANT2;
          else           state_nxt = IDLE;
          arm = (state_nxt != IDLE);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Dwell counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    count <= '0;
    else if (arm)               count <= RELOAD;
    else if (state_nxt == IDLE) count <= '0;
    else if (count != '0)       count <= count - CW'(1);
  end

`ifndef MUX_SEL_PRIORITY_EN
  // Reset value points at in2 so the first tie goes to in1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      last_served2 <= 1'b1;
    else if (arm) last_served2 <= (state_nxt == GRANT2);
  end
`endif

  // Outputs follow the next state so grant, select, out and valid all
  // update on the same edge that samples the request. A source whose
  // request is low never reaches state_nxt == its GRANT, so its data is
  // not captured on that edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      select <= 1'b0;
      grant1 <= 1'b0;
      grant2 <= 1'b0;
      out    <= '0;
      valid  <= 1'b0;
    end else begin
      case (state_nxt)
        GRANT1: begin
          select <= 1'b0;
          grant1 <= 1'b1;
          grant2 <= 1'b0;
          out    <= in1;
          valid  <= 1'b1;
        end
        GRANT2: begin
          select <= 1'b1;
          grant1 <= 1'b0;
          grant2 <= 1'b1;
          out    <= in2;
          valid  <= 1'b1;
        end
        default: begin
          // select and out hold their last values
          grant1 <= 1'b0;
          grant2 <= 1'b0;
          valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux2x1_sel_arbiter.sv
// Testbench for mux2x1_sel_arbiter. Directed vectors push their expected
// post-edge outputs into a queue; a monitor on the falling edge pops and
// compares whatever the DUT is presenting.
module tb_mux2x1_sel_arbiter;

  localparam int W = 4;
`ifdef MUX_SEL_PRIORITY_EN
  localparam int DW = 2;
`else
  localparam int DW = 4;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req1 = 1'b0, req2 = 1'b0;
  logic [W-1:0] in1 = '0, in2 = '0;
  logic         select, grant1, grant2, valid;
  logic [W-1:0] out;

  mux2x1_sel_arbiter #(.WIDTH(W), .DWELL(DW)) dut (
    .clk(clk), .rst(rst), .req1(req1), .req2(req2), .in1(in1), .in2(in2),
    .select(select), .grant1(grant1), .grant2(grant2), .out(out), .valid(valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         sel;
    logic         g1;
    logic         g2;
    logic [W-1:0] o;
    logic         vld;
  } obs_t;

  obs_t q_exp[$];
  int   q_id[$];
  int   checks = 0;
  int   failures = 0;
  int   vec = 0;

  // Monitor
  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      obs_t e, a;
      int   id;
      e  = q_exp.pop_front();
      id = q_id.pop_front();
      a  = '{select, grant1, grant2, out, valid};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL vec%0d got sel=%b g1=%b g2=%b out=%h valid=%b, expected sel=%b g1=%b g2=%b out=%h valid=%b",
                 id, a.sel, a.g1, a.g2, a.o, a.vld, e.sel, e.g1, e.g2, e.o, e.vld);
      end
    end
  end

  task automatic push(input logic s, input logic g1, input logic g2,
                      input logic [W-1:0] o, input logic v);
    obs_t e;
    e = '{s, g1, g2, o, v};
    q_exp.push_back(e);
    q_id.push_back(vec);
    vec++;
  endtask

  // Drive inputs, take one rising edge, expect the given outputs.
  task automatic step(input logic r1, input logic r2,
                      input logic [W-1:0] i1, input logic [W-1:0] i2,
                      input logic s, input logic g1, input logic g2,
                      input logic [W-1:0] o, input logic v);
    req1 = r1; req2 = r2; in1 = i1; in2 = i2;
    @(posedge clk);
    #1;
    push(s, g1, g2, o, v);
  endtask

  // Assert reset between edges; outputs must already be at reset values
  // at the next falling edge, before any rising edge occurs.
  task automatic async_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    #1 push(1'b0, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    // Initial reset, then 5 idle cycles
    async_reset();
    for (int i = 0; i < 5; i++) step(0, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0);

`ifdef MUX_SEL_PRIORITY_EN
    // in1 holds the mux indefinitely while both request
    for (int i = 0; i < 6; i++) step(1, 1, 4'h3, 4'hC, 0, 1, 0, 4'h3, 1);
    // req1 drops: tenure ends at once, in2 granted
    step(0, 1, 4'h3, 4'hC, 1, 0, 1, 4'hC, 1);
    // req1 returns: in2 keeps its 2-cycle tenure, then in1 wins
    step(1, 1, 4'h3, 4'hD, 1, 0, 1, 4'hD, 1);
    step(1, 1, 4'h3, 4'hD, 0, 1, 0, 4'h3, 1);
    step(0, 0, 4'h3, 4'hD, 0, 0, 0, 4'h3, 0);
`else
    // Single requester: gapless re-arm, out tracks in1
    for (int i = 0; i < 9; i++) begin
      logic [W-1:0] d;
      d = W'(i + 1);
      step(1, 0, d, 4'hF, 0, 1, 0, d, 1);
    end
    step(0, 0, 4'hE, 4'hF, 0, 0, 0, 4'h9, 0);

    // Tie and alternation from reset
    async_reset();
    for (int i = 0; i < 12; i++) begin
      logic s;
      s = (i / 4) % 2 == 1;
      step(1, 1, 4'h3, 4'hC, s, ~s, s, s ? 4'hC : 4'h3, 1);
    end
    step(0, 0, 4'h3, 4'hC, 0, 0, 0, 4'h3, 0);

    // Early release of in2
    step(0, 1, 4'h0, 4'h5, 1, 0, 1, 4'h5, 1);
    step(0, 1, 4'h0, 4'h6, 1, 0, 1, 4'h6, 1);
    step(0, 0, 4'h0, 4'h7, 1, 0, 0, 4'h6, 0);

    // GRANT2, then req1 arrives mid-tenure (no preemption), then reset
    step(0, 1, 4'h1, 4'h9, 1, 0, 1, 4'h9, 1);
    step(1, 1, 4'h1, 4'hA, 1, 0, 1, 4'hA, 1);
    async_reset();
    step(1, 1, 4'h1, 4'hA, 0, 1, 0, 4'h1, 1);
    step(1, 1, 4'h4, 4'hA, 0, 1, 0, 4'h4, 1);
    // req1 drops early with req2 pending: handoff captures in2 only
    step(0, 1, 4'hF, 4'h8, 1, 0, 1, 4'h8, 1);
    step(0, 0, 4'hF, 4'h2, 1, 0, 0, 4'h8, 0);
`endif

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && q_exp.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (q_exp.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries left, required 0", q_exp.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
